// File: rtl/display_pkg.sv
// Shared types and constants for the hex/decimal digit formatter.
package display_pkg;

  localparam int NUM_DIGITS_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_PUB  = 2'd2
  } state_t;

  // Largest value showable in decimal on n digits: 10^n - 1.
  // Elaboration-time only; hardware sees a DATA_W-wide constant.
  function automatic longint unsigned dec_max(input int n);
    longint unsigned m;
    m = 64'd1;
    for (int i = 0; i < n; i++) begin
      m = m * 64'd10;
    end
    return m - 64'd1;
  endfunction

endpackage

// File: rtl/hex_digit_formatter_if.sv
// Upstream value handshake plus published display outputs.
interface hex_digit_formatter_if import display_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
  localparam int DATA_W = 4 * NUM_DIGITS;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_value;
  logic                  in_mode_dec;
  logic                  in_lz_blank;
  logic [DATA_W-1:0]     digits;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic                  ovf;
  logic                  out_valid;

  modport master (
    output in_valid, in_value, in_mode_dec, in_lz_blank,
    input  in_ready, digits, digit_blank, ovf, out_valid
  );

  modport slave (
    input  in_valid, in_value, in_mode_dec, in_lz_blank,
    output in_ready, digits, digit_blank, ovf, out_valid
  );
endinterface

// File: rtl/bcd_shift_step.sv
// One double-dabble step: add 3 to each BCD nibble >= 5, then shift the
// whole BCD field left one bit with the binary MSB entering at the bottom.
module bcd_shift_step import display_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic                    bin_msb_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  // Per-nibble adjust, then shift; each nibble's adjusted bit 3 feeds the
  // next nibble's LSB. The top nibble's bit 3 falls off, which is safe
  // because the input value is saturated to the displayable range.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    bcd_o = '0;
    nib   = '0;
    carry = bin_msb_i;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = bcd_i[4*i +: 4];
      if (nib >= 4'd5) begin
        nib = nib + 4'd3;
      end
      bcd_o[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

endmodule

// File: rtl/hex_digit_formatter.sv
// Formats an unsigned value into per-digit nibbles for 7-segment decoders,
// either as raw hex or as saturated decimal (serial double-dabble), with
// optional leading-zero blanking.
module hex_digit_formatter import display_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input logic            clk,
  input logic            rst_n,
  hex_digit_formatter_if.slave bus
);

  localparam int                DATA_W    = 4 * NUM_DIGITS;
  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] DEC_MAX   = DATA_W'(dec_max(NUM_DIGITS));
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     val_q, val_d;
  logic [DATA_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  lz_q, lz_d;
  logic                  pend_q, pend_d;
  logic [DATA_W-1:0]     digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  ovf_q, ovf_d;
  logic                  out_valid_q, out_valid_d;

  logic [DATA_W-1:0]     bcd_step;
  logic [DATA_W-1:0]     pub_digits;
  logic [NUM_DIGITS-1:0] pub_blank;
  logic                  in_over;

  bcd_shift_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
    .bcd_i     (bcd_q),
    .bin_msb_i (val_q[DATA_W-1]),
    .bcd_o     (bcd_step)
  );

  assign in_over    = (bus.in_value > DEC_MAX);
  assign pub_digits = mode_q ? bcd_q : val_q;

  // Leading-zero mask: digit i goes dark when it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    pub_blank = '0;
    zero_run  = lz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (pub_digits[4*i +: 4] == 4'd0);
      pub_blank[i] = zero_run;
    end
  end

  // Next-state and datapath updates for the IDLE/CONV/PUB sequence.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    lz_d        = lz_q;
    pend_d      = pend_q;
    digits_d    = digits_q;
    blank_d     = blank_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mode_d = bus.in_mode_dec;
          lz_d   = bus.in_lz_blank;
          bcd_d  = '0;
          cnt_d  = '0;
          if (bus.in_mode_dec) begin
            val_d   = in_over ? DEC_MAX : bus.in_value;
            pend_d  = in_over;
            state_d = ST_CONV;
          end else begin
            val_d   = bus.in_value;
            pend_d  = 1'b0;
            state_d = ST_PUB;
          end
        end
      end
      ST_CONV: begin
        bcd_d = bcd_step;
        val_d = {val_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_PUB;
        end
      end
      ST_PUB: begin
        digits_d    = pub_digits;
        blank_d     = pub_blank;
        ovf_d       = mode_q & pend_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      val_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      lz_q        <= 1'b0;
      pend_q      <= 1'b0;
      digits_q    <= '0;
      blank_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      lz_q        <= lz_d;
      pend_q      <= pend_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.digits      = digits_q;
  assign bus.digit_blank = blank_q;
  assign bus.ovf         = ovf_q;
  assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_hex_digit_formatter.sv
// Directed bench for hex_digit_formatter with hand-computed expectations.
module tb_hex_digit_formatter;

  localparam int ND = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hex_digit_formatter_if #(.NUM_DIGITS(ND)) bus ();

  hex_digit_formatter #(.NUM_DIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one value, then wait (bounded) for the publish pulse.
  task automatic xfer(input string tag, input logic [23:0] v, input logic dec, input logic lz,
                      output int lat, output int rdy_low);
    check({tag, ".ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_value    = v;
    bus.in_mode_dec = dec;
    bus.in_lz_blank = lz;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat     = 0;
    rdy_low = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      if (bus.in_ready === 1'b0) rdy_low++;
      tick();
      lat++;
    end
  endtask

  // Published values while out_valid is high, then confirm a single pulse.
  task automatic expect_pub(input string tag, input logic [23:0] dig, input logic [5:0] blk,
                            input logic ov);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".digits"}, 32'(bus.digits), 32'(dig));
    check({tag, ".blank"}, 32'(bus.digit_blank), 32'(blk));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(ov));
    tick();
    check({tag, ".pulse_end"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rdy_low, n, pulses;

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_value    = '0;
    bus.in_mode_dec = 1'b0;
    bus.in_lz_blank = 1'b0;
    #2;
    check("rst.digits", 32'(bus.digits), 32'd0);
    check("rst.blank", 32'(bus.digit_blank), 32'd0);
    check("rst.ovf", 32'(bus.ovf), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();

    xfer("hex_abc123", 24'hABC123, 1'b0, 1'b0, lat, rdy_low);
    check("hex_abc123.latency", 32'(lat), 32'd1);
    check("hex_abc123.ready_low", 32'(rdy_low), 32'd1);
    expect_pub("hex_abc123", 24'hABC123, 6'b000000, 1'b0);

    xfer("dec_123456", 24'd123456, 1'b1, 1'b0, lat, rdy_low);
    check("dec_123456.latency", 32'(lat), 32'd25);
    check("dec_123456.ready_low", 32'(rdy_low), 32'd25);
    expect_pub("dec_123456", 24'h123456, 6'b000000, 1'b0);

    xfer("dec_42_lz", 24'd42, 1'b1, 1'b1, lat, rdy_low);
    check("dec_42_lz.latency", 32'(lat), 32'd25);
    expect_pub("dec_42_lz", 24'h000042, 6'b111100, 1'b0);

    xfer("dec_0_lz", 24'd0, 1'b1, 1'b1, lat, rdy_low);
    expect_pub("dec_0_lz", 24'h000000, 6'b111110, 1'b0);

    xfer("dec_ffffff", 24'hFFFFFF, 1'b1, 1'b0, lat, rdy_low);
    expect_pub("dec_ffffff", 24'h999999, 6'b000000, 1'b1);

    xfer("hex_f00_lz", 24'h000F00, 1'b0, 1'b1, lat, rdy_low);
    expect_pub("hex_f00_lz", 24'h000F00, 6'b111000, 1'b0);

    xfer("dec_999999", 24'd999999, 1'b1, 1'b0, lat, rdy_low);
    expect_pub("dec_999999", 24'h999999, 6'b000000, 1'b0);

    xfer("dec_1000000", 24'd1000000, 1'b1, 1'b0, lat, rdy_low);
    expect_pub("dec_1000000", 24'h999999, 6'b000000, 1'b1);

    // in_valid stays high with a changing value during conversion
    bus.in_value    = 24'd7;
    bus.in_mode_dec = 1'b1;
    bus.in_lz_blank = 1'b0;
    bus.in_valid    = 1'b1;
    tick();
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      bus.in_value    = 24'h5A5A00 ^ 24'(n);
      bus.in_mode_dec = 1'b0;
      if (n == 10) begin
        check("hold.digits", 32'(bus.digits), 32'h999999);
        check("hold.ovf", 32'(bus.ovf), 32'd1);
        check("hold.out_valid", 32'(bus.out_valid), 32'd0);
      end
      tick();
      n++;
    end
    check("ignore.latency", 32'(n), 32'd25);
    check("ignore.digits", 32'(bus.digits), 32'h000007);
    check("ignore.ovf", 32'(bus.ovf), 32'd0);
    check("ignore.ready", 32'(bus.in_ready), 32'd1);
    bus.in_value    = 24'h13579B;
    bus.in_mode_dec = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("next.ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    expect_pub("next", 24'h13579B, 6'b000000, 1'b0);

    // reset in the middle of a conversion
    bus.in_value    = 24'd123456;
    bus.in_mode_dec = 1'b1;
    bus.in_lz_blank = 1'b0;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    check("midrst.busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst.digits", 32'(bus.digits), 32'd0);
    check("midrst.blank", 32'(bus.digit_blank), 32'd0);
    check("midrst.ovf", 32'(bus.ovf), 32'd0);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.ready", 32'(bus.in_ready), 32'd1);
    #3 rst_n = 1'b1;
    tick();
    check("postrst.ready", 32'(bus.in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) pulses++;
      tick();
    end
    check("postrst.no_publish", 32'(pulses), 32'd0);

    xfer("hex_1_lz", 24'h000001, 1'b0, 1'b1, lat, rdy_low);
    check("hex_1_lz.latency", 32'(lat), 32'd1);
    expect_pub("hex_1_lz", 24'h000001, 6'b111110, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
